// File: rtl/mdu_pkg.sv
// Shared definitions for the E-stage multiply/divide unit: op encodings,
// controller states and default latencies.
package mdu_pkg;

    typedef enum logic [3:0] {
        MD_NONE  = 4'd0,
        MD_MULT  = 4'd1,
        MD_MULTU = 4'd2,
        MD_DIV   = 4'd3,
        MD_DIVU  = 4'd4,
        MD_MTHI  = 4'd5,
        MD_MTLO  = 4'd6,
        MD_MFHI  = 4'd7,
        MD_MFLO  = 4'd8
    } mdOp_e;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } mdState_e;

    localparam int DEFAULT_MULT_CYCLES = 5;
    localparam int DEFAULT_DIV_CYCLES  = 10;

    function automatic logic isMulDiv(input logic [3:0] op);
        return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
    endfunction

    function automatic int maxOf(input int x, input int y);
        return (x > y) ? x : y;
    endfunction

endpackage

// File: rtl/mdu_if.sv
// Bundle between the E-stage datapath/hazard unit and the MDU controller.
interface mdu_if;

    logic [3:0]  Op;
    logic [31:0] A;
    logic [31:0] B;
    logic        Cancel;
    logic        D_IsMd;
    logic        Start;
    logic        Busy;
    logic        Stall;
    logic [31:0] Result;
    logic [31:0] HI;
    logic [31:0] LO;

    modport master (
        output Op, A, B, Cancel, D_IsMd,
        input  Start, Busy, Stall, Result, HI, LO
    );

    modport slave (
        input  Op, A, B, Cancel, D_IsMd,
        output Start, Busy, Stall, Result, HI, LO
    );

endinterface

// File: rtl/mdu_arith.sv
// Combinational multiply/divide datapath; produces the {HI,LO} pair the
// controller latches at accept time.
module mdu_arith
    import mdu_pkg::*;
(
    input  logic [3:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [63:0] hiLo,
    output logic        div_by_zero
);

    logic signed [63:0] sA64;
    logic signed [63:0] sB64;
    logic        [63:0] uA64;
    logic        [63:0] uB64;

    assign sA64 = {{32{a[31]}}, a};
    assign sB64 = {{32{b[31]}}, b};
    assign uA64 = {32'd0, a};
    assign uB64 = {32'd0, b};

    // The most-negative / -1 quotient overflows, so it is pinned explicitly
    // rather than left to the division operator.
    always_comb begin
        hiLo        = '0;
        div_by_zero = 1'b0;
        case (op)
            MD_MULT:  hiLo = sA64 * sB64;
            MD_MULTU: hiLo = uA64 * uB64;
            MD_DIV: begin
                if (b == 32'd0) begin
                    div_by_zero = 1'b1;
                end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    hiLo = {32'd0, 32'h8000_0000};
                end else begin
                    hiLo = {$signed(a) % $signed(b), $signed(a) / $signed(b)};
                end
            end
            MD_DIVU: begin
                if (b == 32'd0) begin
                    div_by_zero = 1'b1;
                end else begin
                    hiLo = {a % b, a / b};
                end
            end
            default: hiLo = '0;
        endcase
    end

endmodule

// File: rtl/mdu_ctrl.sv
// MDU controller: owns HI/LO, models multi-cycle mult/div latency with a
// down-counter and raises the D-stage stall while the unit is occupied.
module mdu_ctrl
    import mdu_pkg::*;
#(
    parameter int MULT_CYCLES = DEFAULT_MULT_CYCLES,
    parameter int DIV_CYCLES  = DEFAULT_DIV_CYCLES
) (
    input logic  Clk,
    input logic  Rst,
    mdu_if.slave md
);

    localparam int MAX_CYCLES = maxOf(MULT_CYCLES, DIV_CYCLES);
    localparam int CW         = $clog2(MAX_CYCLES + 1);

    mdState_e      state;
    mdState_e      stateNext;
    logic [CW-1:0] count;
    logic [CW-1:0] countNext;
    logic [63:0]   pending;
    logic          pendingWrite;
    logic [63:0]   arithHiLo;
    logic          divByZero;
    logic [31:0]   hiReg;
    logic [31:0]   loReg;
    logic          accept;
    logic          isMult;
    logic          loadPending;
    logic          commit;
    logic          busy;

    mdu_arith uArith (
        .op          (md.Op),
        .a           (md.A),
        .b           (md.B),
        .hiLo        (arithHiLo),
        .div_by_zero (divByZero)
    );

    assign accept = !Rst && !md.Cancel && (state == IDLE) && isMulDiv(md.Op);
    assign isMult = (md.Op == MD_MULT) || (md.Op == MD_MULTU);
    assign busy   = (state == RUN);

    always_comb begin
        stateNext   = state;
        countNext   = count;
        loadPending = 1'b0;
        commit      = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    stateNext   = RUN;
                    countNext   = isMult ? CW'(MULT_CYCLES) : CW'(DIV_CYCLES);
                    loadPending = 1'b1;
                end
            end
            RUN: begin
                if (count == CW'(1)) begin
                    stateNext = IDLE;
                    countNext = '0;
                    commit    = 1'b1;
                end else begin
                    countNext = count - CW'(1);
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    // A divide by zero still occupies the unit, but its commit is suppressed.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state        <= IDLE;
            count        <= '0;
            pending      <= '0;
            pendingWrite <= 1'b0;
        end else begin
            state <= stateNext;
            count <= countNext;
            if (loadPending) begin
                pending      <= arithHiLo;
                pendingWrite <= !divByZero;
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            hiReg <= '0;
            loReg <= '0;
        end else if (commit && pendingWrite) begin
            {hiReg, loReg} <= pending;
        end else if (state == IDLE && !md.Cancel) begin
            if (md.Op == MD_MTHI) hiReg <= md.A;
            if (md.Op == MD_MTLO) loReg <= md.A;
        end
    end

    always_comb begin
        md.Result = '0;
        if (!Rst && !md.Cancel) begin
            if (md.Op == MD_MFHI) md.Result = hiReg;
            if (md.Op == MD_MFLO) md.Result = loReg;
        end
    end

    assign md.Start = accept;
    assign md.Busy  = busy;
    assign md.Stall = !Rst && md.D_IsMd && (accept || busy);
    assign md.HI    = hiReg;
    assign md.LO    = loReg;

endmodule

// File: tb/tb_mdu_ctrl.sv
// Directed bench for mdu_ctrl: a table of mult/div vectors run back to back,
// then hand-written stall, cancel, move and reset sequences.
module tb_mdu_ctrl;
    import mdu_pkg::*;

    localparam int MC = 5;
    localparam int DC = 10;

    logic Clk = 1'b0;
    logic Rst;

    always #5 Clk = ~Clk;

    mdu_if mdBus ();

    mdu_ctrl #(
        .MULT_CYCLES (MC),
        .DIV_CYCLES  (DC)
    ) dut (
        .Clk (Clk),
        .Rst (Rst),
        .md  (mdBus)
    );

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        int          cycles;
        logic [31:0] expHi;
        logic [31:0] expLo;
    } vec_t;

    vec_t vecs[10];
    int   testsRun  = 0;
    int   failCount = 0;

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                 input logic cancel, input logic dIsMd);
        mdBus.Op     = op;
        mdBus.A      = a;
        mdBus.B      = b;
        mdBus.Cancel = cancel;
        mdBus.D_IsMd = dIsMd;
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        testsRun++;
        if (act !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Bounded so a stuck Busy shows up as a wrong length instead of a hang.
    task automatic runToIdle(output int len);
        len = 0;
        while (mdBus.Busy === 1'b1 && len < 40) begin
            len++;
            step();
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        int len;

        vecs[0] = '{MD_MULT,  32'hFFFF_FFFD, 32'd5,        MC, 32'hFFFF_FFFF, 32'hFFFF_FFF1};
        vecs[1] = '{MD_MULTU, 32'hFFFF_FFFF, 32'd2,        MC, 32'h0000_0001, 32'hFFFF_FFFE};
        vecs[2] = '{MD_DIV,   32'd7,         32'hFFFF_FFFE, DC, 32'h0000_0001, 32'hFFFF_FFFD};
        vecs[3] = '{MD_DIVU,  32'd9,         32'd0,        DC, 32'h0000_0001, 32'hFFFF_FFFD};
        vecs[4] = '{MD_DIV,   32'h8000_0000, 32'hFFFF_FFFF, DC, 32'h0000_0000, 32'h8000_0000};
        vecs[5] = '{MD_DIV,   32'hFFFF_FFF9, 32'd2,        DC, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
        vecs[6] = '{MD_DIVU,  32'd100,       32'd7,        DC, 32'h0000_0002, 32'h0000_000E};
        vecs[7] = '{MD_MULTU, 32'h0001_0000, 32'h0001_0000, MC, 32'h0000_0001, 32'h0000_0000};
        vecs[8] = '{MD_MULT,  32'h7FFF_FFFF, 32'h7FFF_FFFF, MC, 32'h3FFF_FFFF, 32'h0000_0001};
        vecs[9] = '{MD_DIV,   32'hFFFF_FFF9, 32'd0,        DC, 32'h3FFF_FFFF, 32'h0000_0001};

        // Reset, with a mult and a D-stage MDU op presented to show reset wins
        Rst = 1'b1;
        applyStimulus(MD_MULT, 32'd1, 32'd1, 1'b0, 1'b1);
        step();
        step();
        checkOutput("rst HI", mdBus.HI, 32'd0);
        checkOutput("rst LO", mdBus.LO, 32'd0);
        checkOutput("rst Busy", {31'd0, mdBus.Busy}, 32'd0);
        checkOutput("rst Start", {31'd0, mdBus.Start}, 32'd0);
        checkOutput("rst Stall", {31'd0, mdBus.Stall}, 32'd0);
        Rst = 1'b0;
        applyStimulus(MD_NONE, 32'd0, 32'd0, 1'b0, 1'b0);

        // Back-to-back vectors: each accept lands in the cycle Busy drops
        for (int i = 0; i < 10; i++) begin
            applyStimulus(vecs[i].op, vecs[i].a, vecs[i].b, 1'b0, 1'b0);
            checkOutput($sformatf("v%0d Start", i), {31'd0, mdBus.Start}, 32'd1);
            checkOutput($sformatf("v%0d Stall", i), {31'd0, mdBus.Stall}, 32'd0);
            step();
            applyStimulus(MD_NONE, 32'd0, 32'd0, 1'b0, 1'b0);
            runToIdle(len);
            checkOutput($sformatf("v%0d busyLen", i), len, vecs[i].cycles);
            checkOutput($sformatf("v%0d HI", i), mdBus.HI, vecs[i].expHi);
            checkOutput($sformatf("v%0d LO", i), mdBus.LO, vecs[i].expLo);
        end

        // Stall held from accept through the last busy cycle
        applyStimulus(MD_MULT, 32'd2, 32'd3, 1'b0, 1'b1);
        checkOutput("stall t", {31'd0, mdBus.Stall}, 32'd1);
        step();
        applyStimulus(MD_NONE, 32'd0, 32'd0, 1'b0, 1'b1);
        for (int k = 1; k <= MC; k++) begin
            checkOutput($sformatf("stall t+%0d", k), {31'd0, mdBus.Stall}, 32'd1);
            step();
        end
        checkOutput("stall end", {31'd0, mdBus.Stall}, 32'd0);
        checkOutput("stall end Busy", {31'd0, mdBus.Busy}, 32'd0);
        checkOutput("stall mult LO", mdBus.LO, 32'd6);

        // Op presented during RUN is ignored
        applyStimulus(MD_MULTU, 32'd3, 32'd4, 1'b0, 1'b0);
        checkOutput("noD Stall", {31'd0, mdBus.Stall}, 32'd0);
        step();
        applyStimulus(MD_MTHI, 32'h0000_DEAD, 32'd0, 1'b0, 1'b0);
        checkOutput("run op Start", {31'd0, mdBus.Start}, 32'd0);
        checkOutput("run noD Stall", {31'd0, mdBus.Stall}, 32'd0);
        step();
        applyStimulus(MD_NONE, 32'd0, 32'd0, 1'b0, 1'b0);
        runToIdle(len);
        checkOutput("run op busyLen", len, MC - 1);
        checkOutput("run op HI", mdBus.HI, 32'd0);
        checkOutput("run op LO", mdBus.LO, 32'd12);

        // Cancelled div and cancelled MTHI leave everything untouched
        applyStimulus(MD_DIV, 32'd100, 32'd3, 1'b1, 1'b0);
        checkOutput("cancel Start", {31'd0, mdBus.Start}, 32'd0);
        step();
        applyStimulus(MD_MTHI, 32'd55, 32'd0, 1'b1, 1'b0);
        checkOutput("cancel Busy", {31'd0, mdBus.Busy}, 32'd0);
        step();
        applyStimulus(MD_NONE, 32'd0, 32'd0, 1'b0, 1'b0);
        checkOutput("cancel HI", mdBus.HI, 32'd0);
        checkOutput("cancel LO", mdBus.LO, 32'd12);

        // Moves to and from HI/LO
        applyStimulus(MD_MTHI, 32'h0000_1234, 32'd0, 1'b0, 1'b0);
        step();
        applyStimulus(MD_MFHI, 32'd0, 32'd0, 1'b0, 1'b0);
        checkOutput("MFHI Result", mdBus.Result, 32'h0000_1234);
        applyStimulus(MD_MTLO, 32'h0000_ABCD, 32'd0, 1'b0, 1'b0);
        step();
        applyStimulus(MD_MFLO, 32'd0, 32'd0, 1'b0, 1'b0);
        checkOutput("MFLO Result", mdBus.Result, 32'h0000_ABCD);
        checkOutput("MTHI kept HI", mdBus.HI, 32'h0000_1234);
        applyStimulus(MD_NONE, 32'd0, 32'd0, 1'b0, 1'b0);
        checkOutput("none Result", mdBus.Result, 32'd0);

        // Reset in the third busy cycle of a mult aborts it
        applyStimulus(MD_MULT, 32'd7, 32'd9, 1'b0, 1'b0);
        checkOutput("rstrun Start", {31'd0, mdBus.Start}, 32'd1);
        step();
        applyStimulus(MD_NONE, 32'd0, 32'd0, 1'b0, 1'b0);
        step();
        step();
        Rst = 1'b1;
        applyStimulus(MD_MULT, 32'd7, 32'd9, 1'b0, 1'b1);
        checkOutput("rstrun Start in rst", {31'd0, mdBus.Start}, 32'd0);
        checkOutput("rstrun Stall in rst", {31'd0, mdBus.Stall}, 32'd0);
        step();
        Rst = 1'b0;
        applyStimulus(MD_NONE, 32'd0, 32'd0, 1'b0, 1'b0);
        checkOutput("rstrun HI", mdBus.HI, 32'd0);
        checkOutput("rstrun LO", mdBus.LO, 32'd0);
        checkOutput("rstrun Busy", {31'd0, mdBus.Busy}, 32'd0);

        // Unit is usable again straight after the abort
        applyStimulus(MD_MULT, 32'd7, 32'd9, 1'b0, 1'b0);
        checkOutput("post rst Start", {31'd0, mdBus.Start}, 32'd1);
        step();
        applyStimulus(MD_NONE, 32'd0, 32'd0, 1'b0, 1'b0);
        runToIdle(len);
        checkOutput("post rst busyLen", len, MC);
        checkOutput("post rst LO", mdBus.LO, 32'd63);

        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule

// File: doc/mdu_ctrl.md
# mdu_ctrl

Controller for the multiply/divide resource in the E stage of the pipelined MIPS core. It accepts MDU operations (mult, multu, div, divu, mthi, mtlo, mfhi, mflo) together with their forwarded operands, and owns the HI/LO registers. It models multi-cycle multiply and divide latency with a busy counter, and raises the stall request that holds any MDU instruction in D while the unit is occupied. Operations killed by an exception or interrupt (Cancel) never start.

## Interface
Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu (≥1)
- DIV_CYCLES, 10, busy cycles for div/divu (≥1)

Ports:
- Clk  in  1  clock
- Rst  in  1  reset, synchronous, active-high
- Op  in  4  E-stage MDU op: 0 none, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 MFHI, 8 MFLO; 9–15 treated as none
- A  in  32  forwarded rs value
- B  in  32  forwarded rt value
- Cancel  in  1  E-stage instruction is being flushed; Op ignored this cycle
- D_IsMd  in  1  D-stage instruction is an MDU op (any of codes 1–8)
- Start  out  1  combinational; a mult/div is accepted this cycle
- Busy  out  1  registered; multi-cycle operation in progress
- Stall  out  1  combinational; D_IsMd && (Start || Busy)
- Result  out  32  combinational; HI for MFHI, LO for MFLO, else 0
- HI  out  32  architectural HI
- LO  out  32  architectural LO

## Operation
- Two states: IDLE (Busy=0) and RUN (Busy=1); a down-counter sized for max(MULT_CYCLES, DIV_CYCLES).
- Accept condition: Op ∈ {1..4}, !Cancel, state IDLE. Start=1 that cycle.
- On accept: compute the 64-bit result from A and B in that cycle and latch it into a pending register. Set the counter to MULT_CYCLES or DIV_CYCLES and enter RUN.
- RUN: the counter decrements each cycle. When it reaches 1, that edge writes pending→{HI,LO}, clears Busy and returns to IDLE.
- Arithmetic:
  - MULT: signed 32×32→64, {HI,LO}.
  - MULTU: unsigned 32×32→64, {HI,LO}.
  - DIV: LO=quotient, HI=remainder, truncating toward zero; remainder takes the dividend's sign. 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.
  - DIVU: unsigned.
  - Divide by zero: full busy period runs; HI/LO are left unchanged.
- MTHI/MTLO with !Cancel in IDLE: HI←A or LO←A at the edge.
- MFHI/MFLO: Result is combinational from the current HI/LO. No state change.
- Any Op≠0 presented while in RUN is ignored; the hazard unit guarantees this by stalling.
- Cancel has no effect on an operation already in RUN, because that instruction has already committed.
- Start is independent of D_IsMd. Stall is 0 when D_IsMd=0.

## Timing
- Reset values: HI=0, LO=0, Busy=0, state IDLE, counter 0, pending 0.
- Start, Stall and Result are 0 while Rst=1.
- Accept at cycle t: Busy=1 during t+1 … t+N, where N is the op's cycle count.
- New HI/LO are visible from t+N+1, and Busy=0 in that same cycle.
- A new mult/div can be accepted at t+N+1.
- Stall is asserted in cycle t if D_IsMd, and remains asserted through t+N if D_IsMd stays high.
- MTHI/MTLO at t: the new value is visible at t+1. MFHI at t+1 returns it.
- Rst mid-RUN: at the next edge, abort the operation, discard pending, zero HI/LO and go to IDLE.
- Simultaneous Rst and accept: reset wins.

## Structure
- Shared package mdu_pkg: the 4-bit op encodings (MD_NONE … MD_MFLO) and default cycle counts.
- Sub-module mdu_arith: purely combinational. Inputs op, A, B. Outputs 64-bit {hi,lo} and div_by_zero.
- mdu_ctrl contains the FSM, counter, pending register, HI/LO and the stall logic.

## Test plan
- MULT A=0xFFFFFFFD (−3), B=5:
  - Start=1 at t; Busy high t+1..t+5.
  - At t+6: HI=0xFFFFFFFF, LO=0xFFFFFFF1.
- MULTU A=0xFFFFFFFF, B=2: after 5 busy cycles, HI=0x00000001, LO=0xFFFFFFFE.
- DIV A=7, B=0xFFFFFFFE (−2): after 10 cycles, LO=0xFFFFFFFD, HI=0x00000001.
- DIVU A=9, B=0: Busy lasts 10 cycles; HI/LO keep their prior values.
- Stall behaviour:
  - MULT accepted at t with D_IsMd=1 held: Stall=1 for t..t+5, 0 at t+6.
  - D_IsMd=0: Stall stays 0 throughout.
- Cancel and reset:
  - DIV with Cancel=1: Start=0, Busy stays 0, HI/LO unchanged.
  - MTHI A=0x1234 then MFHI: Result=0x1234.
  - Rst at t+3 of a MULT: HI=LO=0 and Busy=0 at t+4.
